// File: rtl/mem_ctrl.sv
// Memory controller. It arbitrates the instruction-fetch port and the data port onto a
// single-port 16-bit synchronous memory. Word accesses take two halfword cycles. Byte
// stores use read-modify-write because the memory has no byte enables.
module mem_ctrl #(
    parameter int unsigned MEM_ADDR_WIDTH = 12
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      if_req,
    input  logic [MEM_ADDR_WIDTH:0]   if_addr,
    output logic                      if_ready,
    output logic [15:0]               if_rdata,
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [1:0]                d_size,
    input  logic [MEM_ADDR_WIDTH:0]   d_addr,
    input  logic [31:0]               d_wdata,
    output logic                      d_ready,
    output logic [31:0]               d_rdata,
    output logic                      d_misaligned,
    input  logic [15:0]               MEM_MEMCTRL_from_mem_data,
    output logic                      MEMCTRL_MEM_to_mem_read_enable,
    output logic                      MEMCTRL_MEM_to_mem_write_enable,
    output logic                      MEMCTRL_MEM_to_mem_mem_enable,
    output logic [MEM_ADDR_WIDTH-1:0] MEMCTRL_MEM_to_mem_address,
    output logic [15:0]               MEMCTRL_MEM_to_mem_data
);

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;
    localparam logic [MEM_ADDR_WIDTH-1:0] HalfOne = {{(MEM_ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle, StIfRd, StDRdLo, StDRdHi, StDRmw, StDWrHi, StResp
    } state_e;

    typedef enum logic {PortFetch, PortData} port_e;

    state_e                  state_q, state_d;
    port_e                   last_grant_q, last_grant_d;
    port_e                   owner_q, owner_d;
    logic [1:0]              size_q, size_d;
    logic [MEM_ADDR_WIDTH:0] addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    mis_q, mis_d;
    logic [15:0]             if_rdata_q, if_rdata_d;
    logic [31:0]             d_rdata_q, d_rdata_d;

    logic                      mem_rd, mem_wr;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]               mem_wdata;
    logic                      grant_fetch, grant_data, d_bad;
    logic [MEM_ADDR_WIDTH-1:0] lo_half;
    logic [15:0]               rmw_merged;
    logic                      unused_bits;

    // Alignment rules: half needs an even address, word needs a 4-byte aligned address.
    assign d_bad = (d_size == 2'b11)
                || ((d_size == SizeHalf) && d_addr[0])
                || ((d_size == SizeWord) && (d_addr[1:0] != 2'b00));

    // When both ports are pending, the port that did not win last time is granted.
    assign grant_data  = d_req && (!if_req || (last_grant_q == PortFetch));
    assign grant_fetch = if_req && !grant_data;

    assign lo_half    = addr_q[MEM_ADDR_WIDTH:1];
    assign rmw_merged = addr_q[0] ? {wdata_q[7:0], MEM_MEMCTRL_from_mem_data[7:0]}
                                  : {MEM_MEMCTRL_from_mem_data[15:8], wdata_q[7:0]};

    assign unused_bits = ^{if_addr[0], wdata_q[15:8]};

    // Next-state logic and memory strobes. Memory strobes are Mealy outputs in IDLE.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mis_d        = mis_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        case (state_q)
            StIdle: begin
                if (grant_fetch) begin
                    last_grant_d = PortFetch;
                    owner_d      = PortFetch;
                    mem_rd       = 1'b1;
                    mem_addr     = if_addr[MEM_ADDR_WIDTH:1];
                    state_d      = StIfRd;
                end else if (grant_data) begin
                    last_grant_d = PortData;
                    owner_d      = PortData;
                    size_d       = d_size;
                    addr_d       = d_addr;
                    wdata_d      = d_wdata;
                    mis_d        = d_bad;
                    mem_addr     = d_addr[MEM_ADDR_WIDTH:1];
                    if (d_bad) begin
                        mem_addr = '0;
                        state_d  = StResp;
                    end else if (d_we) begin
                        case (d_size)
                            SizeByte: begin
                                mem_rd  = 1'b1;
                                state_d = StDRmw;
                            end
                            SizeHalf: begin
                                mem_wr    = 1'b1;
                                mem_wdata = d_wdata[15:0];
                                state_d   = StResp;
                            end
                            default: begin
                                mem_wr    = 1'b1;
                                mem_wdata = d_wdata[15:0];
                                state_d   = StDWrHi;
                            end
                        endcase
                    end else begin
                        mem_rd  = 1'b1;
                        state_d = (d_size == SizeWord) ? StDRdLo : StDRdHi;
                    end
                end
            end
            StIfRd: begin
                if_rdata_d = MEM_MEMCTRL_from_mem_data;
                state_d    = StResp;
            end
            StDRdLo: begin
                d_rdata_d[15:0] = MEM_MEMCTRL_from_mem_data;
                mem_rd          = 1'b1;
                mem_addr        = lo_half + HalfOne;
                state_d         = StDRdHi;
            end
            StDRdHi: begin
                if (size_q == SizeWord) begin
                    d_rdata_d[31:16] = MEM_MEMCTRL_from_mem_data;
                end else if (size_q == SizeHalf) begin
                    d_rdata_d = {16'h0000, MEM_MEMCTRL_from_mem_data};
                end else begin
                    d_rdata_d = {24'h000000, addr_q[0] ? MEM_MEMCTRL_from_mem_data[15:8]
                                                       : MEM_MEMCTRL_from_mem_data[7:0]};
                end
                state_d = StResp;
            end
            StDRmw: begin
                mem_wr    = 1'b1;
                mem_addr  = lo_half;
                mem_wdata = rmw_merged;
                state_d   = StResp;
            end
            StDWrHi: begin
                mem_wr    = 1'b1;
                mem_addr  = lo_half + HalfOne;
                mem_wdata = wdata_q[31:16];
                state_d   = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and captured-data registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_grant_q <= PortFetch;
            owner_q      <= PortFetch;
            size_q       <= 2'b00;
            addr_q       <= '0;
            wdata_q      <= '0;
            mis_q        <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mis_q        <= mis_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign if_ready     = (state_q == StResp) && (owner_q == PortFetch);
    assign d_ready      = (state_q == StResp) && (owner_q == PortData);
    assign d_misaligned = d_ready && mis_q;
    assign if_rdata     = if_rdata_q;
    assign d_rdata      = d_rdata_q;

    // Reset is ANDed into the Mealy bus so that a pending request cannot strobe memory while
    // reset is low.
    assign MEMCTRL_MEM_to_mem_read_enable  = mem_rd & reset;
    assign MEMCTRL_MEM_to_mem_write_enable = mem_wr & reset;
    assign MEMCTRL_MEM_to_mem_mem_enable   = (mem_rd | mem_wr) & reset;
    assign MEMCTRL_MEM_to_mem_address      = mem_addr & {MEM_ADDR_WIDTH{reset}};
    assign MEMCTRL_MEM_to_mem_data         = mem_wdata & {16{reset}};

endmodule
